timer_dev: RTL and testbench

TIMER_DEV -- requirements
Module: timer_dev

---
 rtl/timer_dev.sv | 110 +++++++++++
 tb/tb_timer_dev.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Bus-mapped down-counter with CTRL/PRESET/COUNT registers, one-shot or auto-reload, masked interrupt.
// COUNT loads PRESET two edges after EN is written; irq rises N+2 edges after EN; no backpressure on the bus.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t           state;
  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             pend;

  logic wr_ctrl;
  logic wr_preset;
  logic auto_reload;
  logic expire;
  logic en_nxt;
  logic im_nxt;
  logic pend_nxt;

  assign wr_ctrl     = sel & we & (addr == 2'd0);
  assign wr_preset   = sel & we & (addr == 2'd1);
  assign auto_reload = (mode == 2'b01);
  // A zero preset expires on the first counting cycle, same as a preset of one.
  assign expire      = (state == CNT) && en && (count <= CNT_W'(1));

  always_comb begin
    en_nxt = en;
    if (state == INT && !auto_reload) en_nxt = 1'b0;
    if (wr_ctrl) en_nxt = wdata[0];
  end

  always_comb begin
    im_nxt = im;
    if (wr_ctrl) im_nxt = wdata[3];
  end

  // Bus writes to CTRL/PRESET acknowledge the interrupt and take precedence.
  always_comb begin
    pend_nxt = pend;
    if (state == INT && auto_reload) pend_nxt = 1'b0;
    if (expire) pend_nxt = 1'b1;
    if (wr_ctrl || wr_preset) pend_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      en     <= 1'b0;
      mode   <= 2'b00;
      im     <= 1'b0;
      preset <= '0;
      count  <= '0;
      pend   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      en   <= en_nxt;
      im   <= im_nxt;
      pend <= pend_nxt;
      irq  <= pend_nxt & im_nxt;
      if (wr_ctrl)   mode   <= wdata[2:1];
      if (wr_preset) preset <= wdata[CNT_W-1:0];
      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count > CNT_W'(1)) begin
            count <= count - CNT_W'(1);
          end else begin
            count <= '0;
            state <= INT;
          end
        end
        INT: state <= auto_reload ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        2'd0:    rdata = {28'd0, im, mode, en};
        2'd1:    rdata = 32'(preset);
        2'd2:    rdata = 32'(count);
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed and randomized bus traffic against a behavioural timer model.
module tb_timer_dev;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;

  // Reference model: phase 0 idle, 1 reloading, 2 counting down, 3 expired.
  int          m_phase;
  bit          m_en, m_im, m_pend, m_irq;
  bit [1:0]    m_mode;
  bit [31:0]   m_preset, m_count;

  always #5 clk = ~clk;

  timer_dev #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_en = 0; m_im = 0; m_pend = 0; m_irq = 0;
    m_mode = 0; m_preset = 0; m_count = 0;
  endtask

  function automatic logic [31:0] m_read(input bit s, input bit [1:0] a);
    if (!s) return 32'd0;
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_update(input bit s, input bit w, input bit [1:0] a, input bit [31:0] d);
    bit wc, wp;
    wc = s && w && (a == 2'd0);
    wp = s && w && (a == 2'd1);
    case (m_phase)
      0: if (m_en) m_phase = 1;
      1: begin m_count = m_preset; m_phase = 2; end
      2: begin
        if (!m_en) m_phase = 0;
        else if (m_count > 1) m_count = m_count - 1;
        else begin m_count = 0; m_phase = 3; m_pend = 1; end
      end
      default: begin
        if (m_mode == 2'b01) begin m_phase = 1; m_pend = 0; end
        else begin m_phase = 0; m_en = 0; end
      end
    endcase
    if (wc) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_pend = 0;
    end
    if (wp) begin
      m_preset = d; m_pend = 0;
    end
    m_irq = m_pend & m_im;
  endtask

  // Starts and ends at a falling edge; one rising edge per call.
  task automatic step(input bit s, input bit w, input bit [1:0] a, input bit [31:0] d);
    sel = s; we = w; addr = a; wdata = d;
    #1;
    last_rd = rdata;
    chk("rdata", rdata, m_read(s, a));
    @(posedge clk);
    m_update(s, w, a, d);
    @(negedge clk);
    chk("irq", irq, {31'd0, m_irq});
  endtask

  task automatic wr(input bit [1:0] a, input bit [31:0] d); step(1, 1, a, d); endtask
  task automatic rd(input bit [1:0] a); step(1, 0, a, 32'd0); endtask
  task automatic idle(); step(0, 0, 2'd0, 32'd0); endtask

  initial begin
    rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    m_reset();
    #12;
    chk("reset_irq", irq, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    rd(2'd0); chk("reset_ctrl", last_rd, 32'd0);
    rd(2'd1); chk("reset_preset", last_rd, 32'd0);
    rd(2'd2); chk("reset_count", last_rd, 32'd0);

    // One-shot with N=5.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    rd(2'd2); chk("os_cnt_e1", last_rd, 32'd0);
    rd(2'd2); chk("os_cnt_e2", last_rd, 32'd0);
    for (int v = 5; v >= 0; v--) begin
      chk("os_irq_seq", irq, {31'd0, v == 0});
      rd(2'd2); chk("os_count", last_rd, 32'(v));
    end
    idle(); idle();
    chk("os_irq_hold", irq, 32'd1);
    rd(2'd0); chk("os_ctrl_en_cleared", last_rd, 32'h8);
    wr(2'd0, 32'h8);
    chk("os_irq_ack", irq, 32'd0);

    // Auto-reload with N=3: pulse every 5 edges.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      idle();
      chk("ar_pulse", irq, {31'd0, (k >= 5) && ((k - 5) % 5 == 0)});
    end
    wr(2'd0, 32'h3);
    for (int k = 0; k < 12; k++) begin
      rd(2'd2);
      chk("ar_masked", irq, 32'd0);
    end

    // Freeze mid-count, then restart from PRESET.
    wr(2'd0, 32'h0); idle(); idle();
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 5; k++) idle();
    wr(2'd0, 32'h8);
    for (int k = 0; k < 3; k++) begin rd(2'd2); chk("frz_hold", last_rd, 32'd2); end
    wr(2'd0, 32'h9);
    rd(2'd2); chk("frz_restart_e1", last_rd, 32'd2);
    rd(2'd2); chk("frz_restart_e2", last_rd, 32'd2);
    rd(2'd2); chk("frz_reload", last_rd, 32'd6);

    // PRESET=0 behaves as 1; COUNT is read-only; deselected reads are 0.
    wr(2'd0, 32'h0); idle(); idle();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk("p0_irq", irq, {31'd0, k >= 3});
    end
    wr(2'd2, 32'h1234);
    rd(2'd2); chk("count_ro", last_rd, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3); chk("addr3_read", last_rd, 32'd0);
    step(1'b0, 1'b0, 2'd1, 32'd0); chk("nosel_read", last_rd, 32'd0);

    // Asynchronous reset mid-count.
    wr(2'd0, 32'h0); idle(); idle();
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 5; k++) idle();
    sel = 1'b1; we = 1'b0; addr = 2'd2; #1;
    chk("pre_rst_count", rdata, 32'd97);
    #1 rst = 1'b0;
    #1 chk("arst_count", rdata, 32'd0);
    chk("arst_irq", irq, 32'd0);
    addr = 2'd0; #1 chk("arst_ctrl", rdata, 32'd0);
    addr = 2'd1; #1 chk("arst_preset", rdata, 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    wr(2'd1, 32'd7);
    rd(2'd1); chk("post_rst_write", last_rd, 32'd7);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      bit s, w;
      bit [1:0] a;
      bit [31:0] d;
      s = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 7) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 6);
      if (a == 2'd0 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
      step(s, w, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
